// File: rtl/ask4_pkg.sv
// Shared definitions for the 4-ASK symbol source: output levels (1s17),
// frame state encodings, LFSR shape and the Gray-to-level mapper.
package ask4_pkg;

  localparam int LFSR_W      = 15;
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;
  localparam logic [LFSR_W-1:0] LFSR_GUARD_SEED = 15'h0001;

  localparam int SAMPLE_W = 18;
  localparam logic signed [SAMPLE_W-1:0] LEVEL_M3 = -18'sd98304;
  localparam logic signed [SAMPLE_W-1:0] LEVEL_M1 = -18'sd32768;
  localparam logic signed [SAMPLE_W-1:0] LEVEL_P1 = 18'sd32768;
  localparam logic signed [SAMPLE_W-1:0] LEVEL_P3 = 18'sd98304;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_PREAMBLE = 2'd1,
    FS_DATA     = 2'd2
  } frame_state_e;

  // Gray-coded symbol to amplitude: adjacent levels differ in one bit.
  function automatic logic signed [SAMPLE_W-1:0] gray_to_level(input logic [1:0] bits);
    logic signed [SAMPLE_W-1:0] lvl;
    case (bits)
      2'b00:   lvl = LEVEL_M3;
      2'b01:   lvl = LEVEL_M1;
      2'b11:   lvl = LEVEL_P1;
      2'b10:   lvl = LEVEL_P3;
      default: lvl = LEVEL_M3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ask4_symbol_src_lfsr.sv
// PRBS15 (x^15+x^14+1) generator advancing two steps per symbol; the two
// feedback bits of a step pair form the symbol {b1, b0}.
module prbs15_lfsr
  import ask4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 15'h0001
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              step_i,
  output logic [1:0]        bits_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] mid_s;
  logic              fb1_s;
  logic              fb0_s;

  // Two chained LFSR steps, seed load (zero seed would lock up) or hold.
  always_comb begin
    fb1_s = state_q[LFSR_TAP_HI] ^ state_q[LFSR_TAP_LO];
    mid_s = {state_q[LFSR_W-2:0], fb1_s};
    fb0_s = mid_s[LFSR_TAP_HI] ^ mid_s[LFSR_TAP_LO];
    if (load_i) begin
      state_d = (seed_i == {LFSR_W{1'b0}}) ? LFSR_GUARD_SEED : seed_i;
    end else if (step_i) begin
      state_d = {mid_s[LFSR_W-2:0], fb0_s};
    end else begin
      state_d = state_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign bits_o = {fb1_s, fb0_s};

endmodule

// File: rtl/ask4_symbol_src.sv
// 4-ASK symbol source: PRBS15 data, Gray map to 1s17 levels, zero-stuffed at
// the sample rate, framed by an FSM. Define PREAMBLE_EN for P3/M3 preambles.
module ask4_symbol_src
  import ask4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] PRBS_SEED    = 15'h0001,
  parameter int                FRAME_LEN    = 1024,
  parameter int                PREAMBLE_LEN = 16
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        sam_clk_en,
  input  logic        sym_clk_en,
  input  logic        enable,
  input  logic        load_seed,
  input  logic [14:0] seed,
  output logic [17:0] sample_out,
  output logic [1:0]  sym_bits,
  output logic        sym_valid,
  output logic [1:0]  frame_state,
  output logic        frame_start
);

  localparam int MAX_LEN = (FRAME_LEN > PREAMBLE_LEN) ? FRAME_LEN : PREAMBLE_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
`ifdef PREAMBLE_EN
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam frame_state_e     FIRST_STATE   = FS_PREAMBLE;
  localparam logic             START_ON_DATA = 1'b0;
`else
  localparam frame_state_e     FIRST_STATE   = FS_DATA;
  localparam logic             START_ON_DATA = 1'b1;
`endif

  frame_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic [1:0]           bits_q, bits_d;
  logic                 valid_q, valid_d;
  logic                 start_q, start_d;
  logic                 load_s;
  logic                 step_s;
  logic                 emit_s;
  logic                 first_s;
  logic [1:0]           emit_bits_s;
  logic [1:0]           prbs_bits_s;

  prbs15_lfsr #(
    .SEED (PRBS_SEED)
  ) u_lfsr (
    .sys_clk (sys_clk),
    .reset   (reset),
    .load_i  (load_s),
    .seed_i  (seed),
    .step_i  (step_s),
    .bits_o  (prbs_bits_s)
  );

  // Frame sequencing on symbol strobes, then the zero-stuffed sample update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    bits_d      = bits_q;
    valid_d     = valid_q;
    start_d     = 1'b0;
    step_s      = 1'b0;
    emit_s      = 1'b0;
    first_s     = 1'b0;
    emit_bits_s = 2'b00;
    load_s      = load_seed && (state_q == FS_IDLE);

    if (sym_clk_en) begin
      case (state_q)
        FS_IDLE: begin
          if (enable) begin
            state_d = FIRST_STATE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = FS_IDLE;
          end
        end
`ifdef PREAMBLE_EN
        FS_PREAMBLE: begin
          emit_s      = 1'b1;
          emit_bits_s = cnt_q[0] ? 2'b00 : 2'b10;
          first_s     = (cnt_q == {CNT_W{1'b0}});
          if (cnt_q == PRE_LAST) begin
            state_d = FS_DATA;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        FS_DATA: begin
          emit_s      = 1'b1;
          step_s      = 1'b1;
          emit_bits_s = prbs_bits_s;
          first_s     = START_ON_DATA && (cnt_q == {CNT_W{1'b0}});
          // A frame always runs to completion; enable is only sampled here.
          if (cnt_q == FRAME_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = enable ? FIRST_STATE : FS_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = FS_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (sam_clk_en) begin
      if (sym_clk_en && emit_s) begin
        sample_d = gray_to_level(emit_bits_s);
        bits_d   = emit_bits_s;
        valid_d  = 1'b1;
        start_d  = first_s;
      end else begin
        sample_d = {SAMPLE_W{1'b0}};
        valid_d  = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // FSM and registered output stage.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= FS_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      sample_q <= {SAMPLE_W{1'b0}};
      bits_q   <= 2'b00;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      bits_q   <= bits_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
    end
  end

  assign sample_out  = sample_q;
  assign sym_bits    = bits_q;
  assign sym_valid   = valid_q;
  assign frame_state = state_q;
  assign frame_start = start_q;

endmodule

// File: tb/tb_ask4_symbol_src.sv
// Self-checking bench for ask4_symbol_src (FRAME_LEN=8, PREAMBLE_LEN=4);
// follows the PREAMBLE_EN build setting.
module tb_ask4_symbol_src;

  localparam int FLEN = 8;
  localparam int PLEN = 4;
`ifdef PREAMBLE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        sam_clk_en = 1'b0;
  logic        sym_clk_en = 1'b0;
  logic        enable = 1'b0;
  logic        load_seed = 1'b0;
  logic [14:0] seed = 15'h0000;
  logic [17:0] sample_out;
  logic [1:0]  sym_bits;
  logic        sym_valid;
  logic [1:0]  frame_state;
  logic        frame_start;

  ask4_symbol_src #(
    .PRBS_SEED    (15'h0001),
    .FRAME_LEN    (FLEN),
    .PREAMBLE_LEN (PLEN)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en),
    .enable      (enable),
    .load_seed   (load_seed),
    .seed        (seed),
    .sample_out  (sample_out),
    .sym_bits    (sym_bits),
    .sym_valid   (sym_valid),
    .frame_state (frame_state),
    .frame_start (frame_start)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] bits;
    int         level;
    bit         fs;
  } sym_rec_t;

  int checks = 0;
  int failures = 0;
  int phase = 0;

  // reference model state
  int          m_state = 0;
  int          m_cnt = 0;
  logic [14:0] m_lfsr = 15'h0001;
  int          exp_sample = 0;
  logic [1:0]  exp_bits = 2'b00;
  bit          exp_valid = 1'b0;
  bit          exp_new = 1'b0;
  sym_rec_t    sbq[$];
  sym_rec_t    cap[$];
  sym_rec_t    tbl[$];
  bit          cap_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input logic [1:0] b);
    case (b)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  function automatic logic lfsr_shift();
    logic fb;
    fb = m_lfsr[14] ^ m_lfsr[13];
    m_lfsr = {m_lfsr[13:0], fb};
    return fb;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_lfsr = 15'h0001;
    exp_sample = 0; exp_bits = 2'b00; exp_valid = 1'b0; exp_new = 1'b0;
    sbq.delete();
  endtask

  task automatic model_update(input bit sam, input bit sym);
    bit         emitted;
    bit         e_fs;
    logic [1:0] e_bits;
    emitted = 1'b0; e_fs = 1'b0; e_bits = 2'b00;
    exp_new = 1'b0;
    if (load_seed && m_state == 0) m_lfsr = (seed == 15'h0000) ? 15'h0001 : seed;
    if (sym) begin
      if (m_state == 0) begin
        if (enable) begin m_state = PRE ? 1 : 2; m_cnt = 0; end
      end else if (m_state == 1) begin
        emitted = 1'b1;
        e_bits  = (m_cnt % 2 == 0) ? 2'b10 : 2'b00;
        e_fs    = (m_cnt == 0);
        m_cnt++;
        if (m_cnt == PLEN) begin m_state = 2; m_cnt = 0; end
      end else begin
        emitted   = 1'b1;
        e_bits[1] = lfsr_shift();
        e_bits[0] = lfsr_shift();
        e_fs      = !PRE && (m_cnt == 0);
        m_cnt++;
        if (m_cnt == FLEN) begin
          m_cnt = 0;
          m_state = enable ? (PRE ? 1 : 2) : 0;
        end
      end
    end
    if (sam) begin
      if (sym && emitted) begin
        exp_sample = lvl_of(e_bits);
        exp_bits   = e_bits;
        exp_valid  = 1'b1;
        exp_new    = 1'b1;
        sbq.push_back('{bits: e_bits, level: lvl_of(e_bits), fs: e_fs});
      end else begin
        exp_sample = 0;
        exp_valid  = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    sym_rec_t e;
    chk("sym_valid", sym_valid, exp_valid);
    chk("frame_state", frame_state, m_state);
    chk("sym_bits", sym_bits, exp_bits);
    if (exp_new) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sym_level", $signed(sample_out), e.level);
        chk("sym_bits_new", sym_bits, e.bits);
        chk("frame_start", frame_start, e.fs);
        if (cap_en)
          cap.push_back('{bits: sym_bits, level: $signed(sample_out), fs: frame_start});
      end
    end else begin
      chk("sample_out", $signed(sample_out), exp_sample);
      chk("frame_start_idle", frame_start, 0);
    end
  endtask

  // one sys_clk: drive strobes at negedge, sample #1 after the active edge
  task automatic tick();
    bit sam, sym;
    @(negedge sys_clk);
    sam = (phase % 2 == 0);
    sym = (phase % 8 == 0);
    phase++;
    sam_clk_en = sam;
    sym_clk_en = sym;
    if (!reset) model_update(sam, sym);
    @(posedge sys_clk);
    #1;
    check_outputs();
  endtask

  task automatic run_capture(input int n);
    cap.delete();
    cap_en = 1'b1;
    for (int c = 0; c < n * 8 + 40 && cap.size() < n; c++) tick();
    cap_en = 1'b0;
    chk("capture_timeout", (cap.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic compare_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      if (i < cap.size()) begin
        chk({tag, "_level"}, cap[i].level, tbl[i].level);
        chk({tag, "_bits"}, cap[i].bits, tbl[i].bits);
        chk({tag, "_fs"}, cap[i].fs, tbl[i].fs);
      end
    end
  endtask

  task automatic wait_data_cnt(input int n);
    int c;
    c = 0;
    while (!(m_state == 2 && m_cnt == n) && c < 400) begin tick(); c++; end
    chk("wait_data_timeout", (c < 400) ? 1 : 0, 1);
  endtask

  task automatic reset_pulse();
    @(negedge sys_clk);
    reset = 1'b1;
    #1;
    chk("rst_sample", sample_out, 0);
    chk("rst_valid", sym_valid, 0);
    chk("rst_state", frame_state, 0);
    chk("rst_bits", sym_bits, 0);
    chk("rst_fs", frame_start, 0);
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    // expected first symbols of a frame from seed 15'h0001
    for (int i = 0; i < PLEN && PRE; i++)
      tbl.push_back('{bits: (i % 2 == 0) ? 2'b10 : 2'b00, level: (i % 2 == 0) ? 98304 : -98304, fs: (i == 0)});
    for (int i = 0; i < 6; i++)
      tbl.push_back('{bits: 2'b00, level: -98304, fs: (!PRE && i == 0)});
    tbl.push_back('{bits: 2'b01, level: -32768, fs: 1'b0});
    tbl.push_back('{bits: 2'b10, level: 98304, fs: 1'b0});

    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    // idle with enable low
    repeat (200) tick();

    // frame from reset seed, then a second frame start
    enable = 1'b1;
    run_capture(tbl.size());
    compare_table("seq_reset_seed");
    repeat (16 * 8) tick();

    // drop enable at data symbol 3: frame must finish, then IDLE
    wait_data_cnt(3);
    enable = 1'b0;
    repeat (30 * 8) tick();
    chk("idle_after_drop", frame_state, 0);
    chk("idle_sample", sample_out, 0);

    // zero seed in IDLE falls back to 15'h0001
    seed = 15'h0000; load_seed = 1'b1;
    repeat (3) tick();
    load_seed = 1'b0;
    enable = 1'b1;
    run_capture(tbl.size());
    compare_table("seq_zero_seed");

    // seed load during DATA is ignored
    wait_data_cnt(1);
    seed = 15'h7FFF; load_seed = 1'b1;
    repeat (4 * 8) tick();
    load_seed = 1'b0;
    enable = 1'b0;
    repeat (30 * 8) tick();

    // seed load coinciding with frame start, then reset mid-DATA
    seed = 15'h7FFF; load_seed = 1'b1; enable = 1'b1;
    repeat (12) tick();
    load_seed = 1'b0;
    wait_data_cnt(2);
    reset_pulse();
    run_capture(tbl.size());
    compare_table("seq_after_reset");

    enable = 1'b0;
    repeat (30 * 8) tick();
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ask4_symbol_src.md
Name: ask4_symbol_src

Overview:
- Upstream source for the SRRC gold TX filter.
- Generates a 4-ASK symbol stream from a 15-bit PRBS, Gray-maps it to 18-bit signed 1s17 levels, and zero-stuffs it to the sample rate (4 samples/symbol).
- Runs on sys_clk, gated by the clk_gen enables.
- A frame FSM wraps the data in optional preamble bursts.

Parameters:
- PRBS_SEED, 15'h0001, LFSR value after reset.
- FRAME_LEN, 1024, data symbols per frame (≥1).
- PREAMBLE_LEN, 16, preamble symbols per frame (≥1; used only with PREAMBLE_EN).

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  reset: asynchronous, active-high; clock is sys_clk.
- sam_clk_en  in  1  one-sys_clk pulse per sample, from clk_gen.
- sym_clk_en  in  1  one-sys_clk pulse per symbol; always coincides with a sam_clk_en pulse.
- enable  in  1  request to start/continue framing.
- load_seed  in  1  synchronous seed load.
- seed  in  15  seed value.
- sample_out  out  18  signed zero-stuffed sample stream to the TX filter.
- sym_bits  out  2  Gray bits of the current symbol.
- sym_valid  out  1  high for the one sample period that carries a symbol.
- frame_state  out  2  0 IDLE, 1 PREAMBLE, 2 DATA.
- frame_start  out  1  one-sys_clk pulse on entry to the first symbol of a frame.

Behaviour:
- Reset values: sample_out=0, sym_bits=0, sym_valid=0, frame_state=IDLE, frame_start=0, LFSR=PRBS_SEED, counters=0.
- All state advances only on sys_clk edges where the qualifying enable is high.

LFSR:
- Polynomial x^15+x^14+1.
- Each step: fb = s[14]^s[13]; s <= {s[13:0], fb}; output bit = fb.
- Two steps per DATA symbol. First bit is b1, second is b0.
- LFSR does not advance in IDLE or PREAMBLE.

Gray map (1s17):
- 00 → M3 = -98304
- 01 → M1 = -32768
- 11 → P1 = +32768
- 10 → P3 = +98304

FSM transitions (evaluated only on sym_clk_en):
- IDLE → PREAMBLE when enable=1 (→ DATA directly without PREAMBLE_EN).
- PREAMBLE → DATA after PREAMBLE_LEN symbols.
- DATA → PREAMBLE (or DATA with counter restart when PREAMBLE_EN is off) after FRAME_LEN symbols if enable=1; else → IDLE.
- Deasserting enable mid-frame never truncates the frame; the frame completes first.

Output timing:
- On a sym_clk_en cycle in PREAMBLE/DATA, at the next edge: sample_out=level, sym_bits=bits, sym_valid=1. Latency is one sys_clk from sym_clk_en.
- On a sam_clk_en cycle without sym_clk_en: sample_out=0, sym_valid=0, sym_bits held.
- In IDLE: sample_out=0, sym_valid=0.
- Outputs hold between sam_clk_en pulses.
- frame_start pulses with the first symbol's registered output.

Preamble: alternating P3, M3, starting with P3; sym_bits=10/00.

Seed load:
- load_seed is honoured only in IDLE (any cycle, no enable needed); ignored in PREAMBLE/DATA.
- seed=0 loads 15'h0001 (lock-up guard).
- load_seed together with the IDLE→start transition: the load takes effect first, and the frame uses the new seed.

Reset mid-frame: immediate return to reset values; the next frame starts with a fresh preamble and PRBS_SEED.

Optional Feature:
- Macro PREAMBLE_EN.
- Defined: PREAMBLE state and PREAMBLE_LEN counter are present, and each frame is preamble followed by data.
- Undefined: no PREAMBLE state; IDLE → DATA; the data stream is continuous across frame boundaries, and frame_start still pulses every FRAME_LEN symbols.

Decomposition:
- Package ask4_pkg: level constants LEVEL_M3/M1/P1/P3, frame_state encodings, LFSR taps/width.
- One sub-module, prbs15_lfsr: seed load, step enable, 2-bit output per symbol.
- Mapper and FSM live in the top level.

Test Plan:
- Reset, enable=0 for 200 sys_clk → sample_out=0, sym_valid=0, frame_state=0 throughout.
- PREAMBLE_EN off, seed 15'h0001, enable=1 → symbols 1–6 = -98304 (00), symbol 7 = -32768 (01), symbol 8 = +98304 (10); each followed by 3 zero samples; sample_out changes one sys_clk after sym_clk_en.
- PREAMBLE_EN on, PREAMBLE_LEN=4, FRAME_LEN=8 → +98304, -98304, +98304, -98304, then 8 PRBS symbols; frame_start pulses at symbols 1 and 13; frame_state sequence 1, 2, 1.
- enable dropped at data symbol 3 of 8 → remaining 5 symbols sent, then IDLE with sample_out=0.
- load_seed with seed=0 in IDLE → LFSR=15'h0001; load_seed=1 in DATA with seed=15'h7FFF → stream unchanged versus the reference model.
- Reset asserted mid-DATA → outputs zero immediately; after release, the sequence repeats from PRBS_SEED with a new preamble.
